rr_handshake_arbiter: RTL and testbench

RR_HANDSHAKE_ARBITER -- requirements
Module: rr_handshake_arbiter

---
 rtl/rr_handshake_arbiter.sv | 92 +++++++++
 tb/tb_rr_handshake_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter: round-robin arbiter forwarding one requester's data per grant to a single sink
module rr_handshake_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DW-1:0]        data_in,
  output logic [N_REQ-1:0]           ack,
  output logic [DW-1:0]              data_out,
  output logic                       data_valid,
  input  logic                       sink_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       no_error
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, grant_q, grant_d, off, win;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            noerr_q, noerr_d;
  logic [N_REQ-1:0] rot;
  logic [IW:0]     sum;
  logic            timeout;
  logic [DW-1:0]   din [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign din[g] = data_in[g*DW +: DW];
  end
  // Rotate requests so bit 0 corresponds to the requester at ptr, then take the lowest set bit
  always_comb begin
    rot = N_REQ'({req, req} >> ptr_q);
    off = '0;
    for (int k = N_REQ-1; k >= 0; k--) if (rot[k]) off = IW'(k);
  end
  assign sum     = {1'b0, ptr_q} + {1'b0, off};
  assign win     = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
  assign timeout = (cnt_q == 8'(TIMEOUT-1)) && !sink_ready;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // Next-state: a stalled GRANT gives up after TIMEOUT cycles, a ready sink always wins
  always_comb begin
    state_d = (state_q == IDLE)  ? (|req ? GRANT : IDLE) :
              (state_q == GRANT) ? (sink_ready ? ACK : (timeout ? IDLE : GRANT)) :
                                   IDLE;
  end
  // Outputs decoded from state only
  always_comb begin
    data_valid = (state_q == GRANT);
    ack        = (state_q == ACK) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  end
  // Datapath next-state: capture winner on selection, count stalls while granted
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    noerr_d = noerr_q;
    if (state_q == IDLE && |req) begin
      ptr_d   = (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
      grant_d = win;
      data_d  = din[win];
      cnt_d   = '0;
    end
    if (state_q == GRANT && !sink_ready) begin
      cnt_d   = cnt_q + 8'd1;
      noerr_d = noerr_q & ~timeout;
    end
  end
  // Datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      noerr_q <= 1'b1;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      noerr_q <= noerr_d;
    end
  assign data_out = data_q;
  assign grant_id = grant_q;
  assign no_error = noerr_q;
endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// tb_rr_handshake_arbiter: table-driven and sequence checks of the round-robin handshake arbiter
module tb_rr_handshake_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data_in = '0;
  logic        sink_ready = 1'b0;
  logic [3:0]  ack;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [1:0]  grant_id;
  logic        no_error;
  int errors = 0;
  int checks = 0;
  rr_handshake_arbiter #(.N_REQ(4), .DW(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack),
    .data_out(data_out), .data_valid(data_valid), .sink_ready(sink_ready),
    .grant_id(grant_id), .no_error(no_error)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    int          stalls;
    logic [1:0]  id;
  } vec_t;
  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] dinv(input int i);
    logic [3:0] n;
    n = 4'(i);
    return {n, 4'hD, n, 4'hC, n, 4'hB, n, 4'hA};
  endfunction
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    chk("ack_onehot0", {31'b0, $onehot0(ack)}, 32'd1);
    chk("dv_ack_excl", {31'b0, data_valid && (|ack)}, 32'd0);
    if (|ack) chk("ack_only_after_grant", {31'b0, prev_dv}, 32'd1);
    prev_dv = data_valid;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t v[10];
    exp_t e;
    logic [7:0] xd;
    int ids[5];
    ids = '{1, 2, 3, 0, 1};
    v[0] = '{4'b0001, 32'h000000A5, 0,  2'd0};
    v[1] = '{4'b1111, dinv(1),      0,  2'd1};
    v[2] = '{4'b1111, dinv(2),      0,  2'd2};
    v[3] = '{4'b1111, dinv(3),      0,  2'd3};
    v[4] = '{4'b1111, dinv(4),      0,  2'd0};
    v[5] = '{4'b0001, dinv(5),      5,  2'd0};
    v[6] = '{4'b1000, dinv(6),      0,  2'd3};
    v[7] = '{4'b0110, dinv(7),      0,  2'd1};
    v[8] = '{4'b0010, dinv(8),      0,  2'd1};
    v[9] = '{4'b1101, dinv(9),      14, 2'd2};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dv", {31'b0, data_valid}, 0);
    chk("rst_ack", {28'b0, ack}, 0);
    chk("rst_data", {24'b0, data_out}, 0);
    chk("rst_gid", {30'b0, grant_id}, 0);
    chk("rst_noerr", {31'b0, no_error}, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("idle_dv", {31'b0, data_valid}, 0);
    for (int i = 0; i < 10; i++) begin
      xd = v[i].din[v[i].id*8 +: 8];
      req = v[i].req;
      data_in = v[i].din;
      sink_ready = 1'b0;
      sb.push_back('{v[i].id, xd});
      step();
      chk($sformatf("v%0d_dv", i), {31'b0, data_valid}, 1);
      chk($sformatf("v%0d_gid", i), {30'b0, grant_id}, {30'b0, v[i].id});
      chk($sformatf("v%0d_data", i), {24'b0, data_out}, {24'b0, xd});
      req[v[i].id] = 1'b0;
      data_in = ~data_in;
      for (int s = 0; s < v[i].stalls; s++) begin
        step();
        chk($sformatf("v%0d_hold_dv", i), {31'b0, data_valid}, 1);
        chk($sformatf("v%0d_hold_data", i), {24'b0, data_out}, {24'b0, xd});
        chk($sformatf("v%0d_hold_ack", i), {28'b0, ack}, 0);
      end
      sink_ready = 1'b1;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_sb_gid", i), {30'b0, grant_id}, {30'b0, e.id});
        chk($sformatf("v%0d_sb_data", i), {24'b0, data_out}, {24'b0, e.data});
      end
      step();
      chk($sformatf("v%0d_ack", i), {28'b0, ack}, {28'b0, 4'b0001 << v[i].id});
      chk($sformatf("v%0d_ack_dv", i), {31'b0, data_valid}, 0);
      chk($sformatf("v%0d_noerr", i), {31'b0, no_error}, 1);
      sink_ready = 1'b0;
      step();
      chk($sformatf("v%0d_idle_ack", i), {28'b0, ack}, 0);
      chk($sformatf("v%0d_idle_dv", i), {31'b0, data_valid}, 0);
    end
    req = 4'b1001;
    data_in = 32'hF4F3F2F1;
    sink_ready = 1'b0;
    step();
    chk("to_gid", {30'b0, grant_id}, 3);
    chk("to_data", {24'b0, data_out}, 32'hF4);
    for (int s = 2; s <= 15; s++) begin
      step();
      chk($sformatf("to_dv_c%0d", s), {31'b0, data_valid}, 1);
      chk($sformatf("to_noerr_c%0d", s), {31'b0, no_error}, 1);
    end
    step();
    chk("to_idle_dv", {31'b0, data_valid}, 0);
    chk("to_no_ack", {28'b0, ack}, 0);
    chk("to_noerr_low", {31'b0, no_error}, 0);
    step();
    chk("to_next_gid", {30'b0, grant_id}, 0);
    chk("to_next_data", {24'b0, data_out}, 32'hF1);
    sink_ready = 1'b1;
    step();
    chk("to_next_ack", {28'b0, ack}, 4'b0001);
    chk("to_noerr_sticky", {31'b0, no_error}, 0);
    req = '0;
    sink_ready = 1'b0;
    step();
    req = 4'b1111;
    sink_ready = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("fair_dv_k%0d", k), {31'b0, data_valid}, {31'b0, k % 3 == 1});
      chk($sformatf("fair_ack_k%0d", k), {28'b0, ack},
          (k % 3 == 2) ? {28'b0, 4'b0001 << ids[(k-2)/3]} : 32'd0);
      if (k % 3 == 1) chk($sformatf("fair_gid_k%0d", k), {30'b0, grant_id}, 32'(ids[(k-1)/3]));
    end
    req = '0;
    sink_ready = 1'b0;
    step();
    chk("fair_idle_dv", {31'b0, data_valid}, 0);
    req = 4'b1100;
    data_in = 32'h44332211;
    step();
    chk("rg_gid", {30'b0, grant_id}, 2);
    chk("rg_dv", {31'b0, data_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rg_async_dv", {31'b0, data_valid}, 0);
    chk("rg_async_ack", {28'b0, ack}, 0);
    chk("rg_async_gid", {30'b0, grant_id}, 0);
    chk("rg_async_data", {24'b0, data_out}, 0);
    chk("rg_async_noerr", {31'b0, no_error}, 1);
    step();
    chk("rg_held_dv", {31'b0, data_valid}, 0);
    chk("rg_held_ack", {28'b0, ack}, 0);
    rst_n = 1'b1;
    step();
    chk("rg_post_dv", {31'b0, data_valid}, 1);
    chk("rg_post_gid", {30'b0, grant_id}, 2);
    chk("rg_post_data", {24'b0, data_out}, 32'h33);
    sink_ready = 1'b1;
    step();
    chk("rg_post_ack", {28'b0, ack}, 4'b0100);
    req = '0;
    sink_ready = 1'b0;
    step();
    chk("rg_idle_ack", {28'b0, ack}, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
